monitor_host: RTL and testbench

Hardware initiator for the serial monitor protocol: builds LOAD (01), DUMP (02) and EXEC (03) frames, sends them one byte at a time through a UART transmitter, and checks every echoed byte. It lets an on-board master, such as a second board or a test harness, drive the monitor without a PC. It sits between a command/data client and a UART instance: `tx_*` go to the UART transmit side and `rx_*` come from its receive side.

---
 rtl/monitor_host.sv | 279 +++++++++++++++++++++++++++
 tb/tb_monitor_host.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/monitor_host.sv
// monitor_host: hardware initiator for the serial monitor protocol.
//
// Builds LOAD (01), DUMP (02) and EXEC (03) frames and sends them one byte at
// a time through a UART transmitter. Every transmitted byte must come back as
// an echo before the next one is sent. DUMP frames then collect `len` bytes
// from the monitor and hand them to the client.
//
// Ports:
//   CLK, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op, cmd_addr, cmd_len are
//                         sampled on the accepting edge
//   wr_data/wr_valid      LOAD payload from the client; wr_ready pulses once
//                         per consumed byte
//   rd_data/rd_valid      DUMP bytes to the client, one-cycle pulse each
//   tx_byte/tx_start      byte and strobe to the UART transmitter
//   tx_busy               UART transmitter busy
//   rx_byte/rx_strobe     byte and strobe from the UART receiver
//   busy                  high whenever the FSM is not idle
//   done                  one-cycle pulse on successful completion
//   error                 sticky error flag; cleared by the next accepted command
//   dbg_state             current FSM state
//
// Handshake semantics: a command transfers on a rising edge where cmd_valid
// and cmd_ready are both high; cmd_ready depends only on state, never on
// cmd_valid. A payload byte transfers on an edge where the FSM waits for
// payload and wr_valid is high; wr_ready reports that transfer one cycle later.
module monitor_host #(
    parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
    input  logic        CLK,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_start,
    input  logic        tx_busy,
    input  logic [7:0]  rx_byte,
    input  logic        rx_strobe,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_TX   = 3'd1,
        HDR_ECHO = 3'd2,
        PAY_GET  = 3'd3,
        PAY_TX   = 3'd4,
        PAY_ECHO = 3'd5,
        DUMP_RX  = 3'd6,
        FINISH   = 3'd7
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'd1;
    localparam logic [1:0] OP_DUMP = 2'd2;

    state_t      state_q, state_n;
    logic [1:0]  op_q, op_n;
    logic [15:0] addr_q, addr_n;
    logic [15:0] len_q, len_n;
    logic [2:0]  idx_q, idx_n;
    logic [15:0] remain_q, remain_n;
    logic [15:0] timer_q, timer_n;
    logic [7:0]  pay_q, pay_n;

    logic [7:0]  tx_byte_n, rd_data_n;
    logic        tx_start_n, wr_ready_n, rd_valid_n, done_n, error_n;
    logic [7:0]  hdr_byte;
    logic        can_tx;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // The UART raises tx_busy one cycle after it sees tx_start, so tx_busy
    // is not trusted during the cycle in which our own strobe is high.
    assign can_tx = !tx_busy && !tx_start;

    always_comb begin
        hdr_byte = 8'h00;
        case (idx_q)
            3'd0:    hdr_byte = {6'b0, op_q};
            3'd1:    hdr_byte = 8'h00;
            3'd2:    hdr_byte = addr_q[15:8];
            3'd3:    hdr_byte = addr_q[7:0];
            3'd4:    hdr_byte = len_q[15:8];
            3'd5:    hdr_byte = len_q[7:0];
            default: hdr_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_n    = state_q;
        op_n       = op_q;
        addr_n     = addr_q;
        len_n      = len_q;
        idx_n      = idx_q;
        remain_n   = remain_q;
        timer_n    = timer_q;
        pay_n      = pay_q;
        tx_byte_n  = tx_byte;
        tx_start_n = 1'b0;
        wr_ready_n = 1'b0;
        rd_data_n  = rd_data;
        rd_valid_n = 1'b0;
        done_n     = 1'b0;
        error_n    = error;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_op == 2'd0) begin
                        error_n = 1'b1;
                    end else begin
                        op_n    = cmd_op;
                        addr_n  = cmd_addr;
                        len_n   = cmd_len;
                        idx_n   = 3'd0;
                        error_n = 1'b0;
                        state_n = HDR_TX;
                    end
                end
            end

            HDR_TX: begin
                if (can_tx) begin
                    tx_byte_n  = hdr_byte;
                    tx_start_n = 1'b1;
                    timer_n    = TIMEOUT;
                    state_n    = HDR_ECHO;
                end
            end

            HDR_ECHO: begin
                // A strobe takes priority over an expiring timer.
                if (rx_strobe) begin
                    if (rx_byte != hdr_byte) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        idx_n = idx_q + 3'd1;
                        if (idx_q != 3'd5) begin
                            state_n = HDR_TX;
                        end else begin
                            remain_n = len_q;
                            if (op_q == OP_LOAD && len_q != 16'd0) begin
                                state_n = PAY_GET;
                            end else if (op_q == OP_DUMP && len_q != 16'd0) begin
                                timer_n = TIMEOUT;
                                state_n = DUMP_RX;
                            end else begin
                                done_n  = 1'b1;
                                state_n = FINISH;
                            end
                        end
                    end
                end else if (timer_q == 16'd0) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_q - 16'd1;
                end
            end

            PAY_GET: begin
                if (wr_valid) begin
                    pay_n      = wr_data;
                    wr_ready_n = 1'b1;
                    state_n    = PAY_TX;
                end
            end

            PAY_TX: begin
                if (can_tx) begin
                    tx_byte_n  = pay_q;
                    tx_start_n = 1'b1;
                    timer_n    = TIMEOUT;
                    state_n    = PAY_ECHO;
                end
            end

            PAY_ECHO: begin
                if (rx_strobe) begin
                    if (rx_byte != pay_q) begin
                        error_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        remain_n = remain_q - 16'd1;
                        if (remain_q == 16'd1) begin
                            done_n  = 1'b1;
                            state_n = FINISH;
                        end else begin
                            state_n = PAY_GET;
                        end
                    end
                end else if (timer_q == 16'd0) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_q - 16'd1;
                end
            end

            DUMP_RX: begin
                if (rx_strobe) begin
                    rd_data_n  = rx_byte;
                    rd_valid_n = 1'b1;
                    remain_n   = remain_q - 16'd1;
                    timer_n    = TIMEOUT;
                    if (remain_q == 16'd1) begin
                        done_n  = 1'b1;
                        state_n = FINISH;
                    end
                end else if (timer_q == 16'd0) begin
                    error_n = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer_q - 16'd1;
                end
            end

            // done was registered on entry, so it is high during this cycle.
            FINISH: begin
                state_n = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            op_q     <= 2'd0;
            addr_q   <= 16'd0;
            len_q    <= 16'd0;
            idx_q    <= 3'd0;
            remain_q <= 16'd0;
            timer_q  <= 16'd0;
            pay_q    <= 8'd0;
            tx_byte  <= 8'd0;
            tx_start <= 1'b0;
            wr_ready <= 1'b0;
            rd_data  <= 8'd0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
        end else begin
            state_q  <= state_n;
            op_q     <= op_n;
            addr_q   <= addr_n;
            len_q    <= len_n;
            idx_q    <= idx_n;
            remain_q <= remain_n;
            timer_q  <= timer_n;
            pay_q    <= pay_n;
            tx_byte  <= tx_byte_n;
            tx_start <= tx_start_n;
            wr_ready <= wr_ready_n;
            rd_data  <= rd_data_n;
            rd_valid <= rd_valid_n;
            done     <= done_n;
            error    <= error_n;
        end
    end

endmodule

// File: tb/tb_monitor_host.sv
// tb_monitor_host: directed bench for monitor_host with a UART loopback model,
// a payload client, and expected-byte queues checked by a monitor process.
module tb_monitor_host;

    localparam logic [15:0] TO = 16'd16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_addr = 16'd0;
    logic [15:0] cmd_len = 16'd0;
    logic [7:0]  wr_data = 8'd0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [7:0]  tx_byte;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_strobe = 1'b0;
    logic        busy;
    logic        done;
    logic        error;
    logic [2:0]  dbg_state;

    logic busy_m = 1'b0;
    logic hold_busy = 1'b0;
    assign tx_busy = busy_m | hold_busy;

    monitor_host #(.TIMEOUT(TO)) dut (
        .CLK       (clk),
        .reset_n   (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_tx_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] wr_q[$];
    logic [7:0] dump_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int tx_cnt = 0, rd_cnt = 0, done_cnt = 0, wr_cnt = 0;
    int last_tx_cyc = 0, err_cyc = 0;
    logic err_prev = 1'b0;
    logic [7:0] e_tx, e_rd, m_byte;

    int echo_cnt = 0;
    int echo_limit = 99;
    int corrupt_idx = 99;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (tx_start) begin
            tx_cnt++;
            last_tx_cyc = cyc;
            if (exp_tx_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte %02h, expected no transmit", tx_byte);
            end else begin
                e_tx = exp_tx_q.pop_front();
                check("tx_byte", {24'd0, tx_byte}, {24'd0, e_tx});
            end
        end
        if (rd_valid) begin
            rd_cnt++;
            if (exp_rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: got byte %02h, expected no dump byte", rd_data);
            end else begin
                e_rd = exp_rd_q.pop_front();
                check("rd_data", {24'd0, rd_data}, {24'd0, e_rd});
            end
        end
        if (done) done_cnt++;
        if (wr_ready) wr_cnt++;
        if (error && !err_prev) err_cyc = cyc;
        err_prev = error;
    end

    // ---------------- payload client ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (wr_ready && wr_q.size() > 0) void'(wr_q.pop_front());
            if (wr_q.size() > 0) begin
                wr_valid = 1'b1;
                wr_data  = wr_q[0];
            end else begin
                wr_valid = 1'b0;
                wr_data  = 8'd0;
            end
        end
    end

    // ---------------- UART loopback / monitor model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) begin
                m_byte = tx_byte;
                @(posedge clk); #1 busy_m = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                if (echo_cnt < echo_limit) begin
                    rx_byte   = (echo_cnt == corrupt_idx) ? 8'hFF : m_byte;
                    rx_strobe = 1'b1;
                end
                echo_cnt++;
                @(posedge clk); #1 rx_strobe = 1'b0;
                @(posedge clk); #1 busy_m = 1'b0;
                if (echo_cnt == 6) begin
                    while (dump_q.size() > 0) begin
                        repeat (2) @(posedge clk);
                        #1;
                        rx_byte   = dump_q.pop_front();
                        rx_strobe = 1'b1;
                        @(posedge clk); #1 rx_strobe = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic push_hdr(input logic [1:0] op, input logic [15:0] a, input logic [15:0] l);
        exp_tx_q.push_back({6'd0, op});
        exp_tx_q.push_back(8'h00);
        exp_tx_q.push_back(a[15:8]);
        exp_tx_q.push_back(a[7:0]);
        exp_tx_q.push_back(l[15:8]);
        exp_tx_q.push_back(l[7:0]);
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] l);
        int k;
        k = 0;
        @(negedge clk);
        while (!cmd_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("cmd_ready_before_issue", {31'd0, cmd_ready}, 32'd1);
        echo_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_len   = l;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 2000) begin
            @(negedge clk);
            k++;
        end
        #1;
        check(name, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_state(input logic [2:0] s, input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (dbg_state != s && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, {29'd0, dbg_state}, {29'd0, s});
    endtask

    // ---------------- test sequence ----------------
    int d0, w0, r0, t0;

    initial begin
        tick(3);
        #1;
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_outputs", {busy, tx_start, done, error, wr_ready, rd_valid}, 32'd0);
        check("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(2);

        // LOAD 2 bytes
        d0 = done_cnt; w0 = wr_cnt;
        push_hdr(2'd1, 16'h2000, 16'd2);
        exp_tx_q.push_back(8'hAA);
        exp_tx_q.push_back(8'h55);
        wr_q.push_back(8'hAA);
        wr_q.push_back(8'h55);
        issue(2'd1, 16'h2000, 16'd2);
        wait_idle("load_idle");
        check("load_done", done_cnt - d0, 32'd1);
        check("load_wr_ready", wr_cnt - w0, 32'd2);
        check("load_error", {31'd0, error}, 32'd0);
        check("load_tx_left", exp_tx_q.size(), 32'd0);
        tick(4);

        // DUMP 3 bytes
        d0 = done_cnt; r0 = rd_cnt;
        push_hdr(2'd2, 16'h0100, 16'd3);
        dump_q.push_back(8'h11); dump_q.push_back(8'h22); dump_q.push_back(8'h33);
        exp_rd_q.push_back(8'h11); exp_rd_q.push_back(8'h22); exp_rd_q.push_back(8'h33);
        issue(2'd2, 16'h0100, 16'd3);
        wait_idle("dump_idle");
        check("dump_rd_count", rd_cnt - r0, 32'd3);
        check("dump_rd_left", exp_rd_q.size(), 32'd0);
        check("dump_done", done_cnt - d0, 32'd1);
        check("dump_error", {31'd0, error}, 32'd0);
        check("dump_tx_left", exp_tx_q.size(), 32'd0);
        tick(4);

        // EXEC
        d0 = done_cnt; w0 = wr_cnt; t0 = tx_cnt;
        push_hdr(2'd3, 16'h2000, 16'h1234);
        issue(2'd3, 16'h2000, 16'h1234);
        wait_idle("exec_idle");
        check("exec_done", done_cnt - d0, 32'd1);
        check("exec_no_wr", wr_cnt - w0, 32'd0);
        check("exec_tx_count", tx_cnt - t0, 32'd6);
        check("exec_error", {31'd0, error}, 32'd0);
        tick(4);

        // Echo mismatch on H3
        d0 = done_cnt; t0 = tx_cnt;
        corrupt_idx = 3;
        push_hdr(2'd1, 16'h2000, 16'd1);
        exp_tx_q.push_back(8'hC3);
        wr_q.push_back(8'hC3);
        issue(2'd1, 16'h2000, 16'd1);
        wait_idle("mm_idle");
        check("mm_error", {31'd0, error}, 32'd1);
        check("mm_no_done", done_cnt - d0, 32'd0);
        check("mm_tx_count", tx_cnt - t0, 32'd4);
        check("mm_tx_unsent", exp_tx_q.size(), 32'd3);
        exp_tx_q.delete();
        wr_q.delete();
        corrupt_idx = 99;
        tick(20);
        check("mm_no_more_tx", tx_cnt - t0, 32'd4);
        d0 = done_cnt;
        push_hdr(2'd3, 16'h0005, 16'h0000);
        issue(2'd3, 16'h0005, 16'h0000);
        check("mm_error_cleared", {31'd0, error}, 32'd0);
        wait_idle("mm_next_idle");
        check("mm_next_done", done_cnt - d0, 32'd1);
        tick(4);

        // Timeout after H1 echo
        d0 = done_cnt; t0 = tx_cnt;
        echo_limit = 2;
        push_hdr(2'd2, 16'h4000, 16'd5);
        issue(2'd2, 16'h4000, 16'd5);
        wait_idle("to_idle");
        check("to_error", {31'd0, error}, 32'd1);
        check("to_tx_count", tx_cnt - t0, 32'd3);
        check("to_latency", err_cyc - last_tx_cyc, 32'd17);
        check("to_no_done", done_cnt - d0, 32'd0);
        exp_tx_q.delete();
        echo_limit = 99;
        tick(10);

        // DUMP with len=0
        d0 = done_cnt; r0 = rd_cnt; t0 = tx_cnt;
        push_hdr(2'd2, 16'h1234, 16'd0);
        issue(2'd2, 16'h1234, 16'd0);
        wait_idle("dump0_idle");
        check("dump0_done", done_cnt - d0, 32'd1);
        check("dump0_no_rd", rd_cnt - r0, 32'd0);
        check("dump0_tx_count", tx_cnt - t0, 32'd6);
        check("dump0_error", {31'd0, error}, 32'd0);
        tick(4);

        // op=0
        d0 = done_cnt; t0 = tx_cnt;
        issue(2'd0, 16'h2000, 16'd4);
        check("op0_error", {31'd0, error}, 32'd1);
        check("op0_idle", {31'd0, busy}, 32'd0);
        tick(10);
        check("op0_no_tx", tx_cnt - t0, 32'd0);
        check("op0_no_done", done_cnt - d0, 32'd0);

        // Reset during PAY_TX
        d0 = done_cnt;
        push_hdr(2'd1, 16'h3000, 16'd2);
        exp_tx_q.push_back(8'h5A);
        wr_q.push_back(8'h5A);
        wr_q.push_back(8'h66);
        issue(2'd1, 16'h3000, 16'd2);
        wait_state(3'd3, "rst_reach_pay_get");
        hold_busy = 1'b1;
        wait_state(3'd4, "rst_reach_pay_tx");
        rst_n = 1'b0;
        #1;
        check("rst_mid_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_mid_outputs", {busy, tx_start, done, error, wr_ready, rd_valid}, 32'd0);
        check("rst_mid_state", {29'd0, dbg_state}, 32'd0);
        check("rst_mid_unsent", exp_tx_q.size(), 32'd1);
        exp_tx_q.delete();
        wr_q.delete();
        tick(5);
        @(negedge clk);
        hold_busy = 1'b0;
        rst_n = 1'b1;
        t0 = tx_cnt;
        tick(20);
        #1;
        check("rst_after_idle", {cmd_ready, busy}, 32'd2);
        check("rst_after_no_tx", tx_cnt - t0, 32'd0);
        check("rst_after_no_done", done_cnt - d0, 32'd0);
        check("rst_after_error", {31'd0, error}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
